// File: rtl/timer_seq_ctrl.sv
// APB master sequencer for a timer: loads and starts the timer, then polls its status
// register for a programmed number of overflow/underflow events before stopping it.
`timescale 1ns/1ps
module timer_seq_ctrl #(
  parameter logic [7:0]  ADDR_TDR   = 8'h00,
  parameter logic [7:0]  ADDR_TCR   = 8'h01,
  parameter logic [7:0]  ADDR_TSR   = 8'h02,
  parameter logic [15:0] POLL_LIMIT = 16'd1000
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_tdr,
  input  logic [7:0] cmd_tcr,
  input  logic [3:0] cmd_count,
  input  logic       abort,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_TDR, S_WR_LOAD, S_WR_RUN, S_POLL, S_CLR, S_STOP, S_FIN
  } state_e;

  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SLV  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_ABT  = 2'b11;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [7:0]  tdr_q, tdr_d;
  logic [2:0]  mode_q, mode_d;      // {up/down, clock select[1:0]}
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] poll_q, poll_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        in_xfer;
  logic [7:0]  x_addr;
  logic        x_write;
  logic [7:0]  x_data;
  logic        xfer_done;
  logic        can_abort;
  logic [15:0] poll_inc;
  logic [3:0]  cnt_dec;
  logic        unused_bits;

  assign unused_bits = ^{cmd_tcr[7:6], cmd_tcr[4:2], prdata[7:2]};

  function automatic logic [1:0] first_err(input logic [1:0] cur, input logic [1:0] code);
    return (cur == ERR_NONE) ? code : cur;
  endfunction

  // Each bus state owns exactly one transfer; its address/data are constant while in it.
  always_comb begin
    in_xfer = 1'b1;
    x_addr  = 8'h00;
    x_write = 1'b0;
    x_data  = 8'h00;
    case (state_q)
      S_WR_TDR:  begin x_addr = ADDR_TDR; x_write = 1'b1; x_data = tdr_q; end
      S_WR_LOAD: begin
        x_addr  = ADDR_TCR;
        x_write = 1'b1;
        x_data  = {1'b1, 1'b0, mode_q[2], 1'b0, 2'b00, mode_q[1:0]};
      end
      S_WR_RUN:  begin
        x_addr  = ADDR_TCR;
        x_write = 1'b1;
        x_data  = {1'b0, 1'b0, mode_q[2], 1'b1, 2'b00, mode_q[1:0]};
      end
      S_POLL:    begin x_addr = ADDR_TSR; x_write = 1'b0; end
      S_CLR:     begin x_addr = ADDR_TSR; x_write = 1'b1; end
      S_STOP:    begin x_addr = ADDR_TCR; x_write = 1'b1; end
      default:   in_xfer = 1'b0;
    endcase
  end

  assign psel      = in_xfer && (phase_q != PH_GAP);
  assign penable   = in_xfer && (phase_q == PH_ACCESS);
  assign pwrite    = x_write;
  assign paddr     = x_addr;
  assign pwdata    = x_data;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN) && (err_code_q == ERR_NONE);
  assign err       = (state_q == S_FIN) && (err_code_q != ERR_NONE);
  assign err_code  = err_code_q;

  assign xfer_done = penable && pready;
  // Abort is honoured only between transfers or at a completing edge, and never once stopping.
  assign can_abort = abort && (state_q inside {S_WR_TDR, S_WR_LOAD, S_WR_RUN, S_POLL, S_CLR})
                     && ((phase_q == PH_GAP) || xfer_done);
  assign poll_inc  = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
  assign cnt_dec   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tdr_d      = tdr_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    poll_d     = poll_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          tdr_d      = cmd_tdr;
          mode_d     = {cmd_tcr[5], cmd_tcr[1:0]};
          cnt_d      = (cmd_count == 4'd0) ? 4'd1 : cmd_count;
          poll_d     = 16'd0;
          err_code_d = ERR_NONE;
          state_d    = S_WR_TDR;
          phase_d    = PH_GAP;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        phase_d = PH_GAP;
      end
      default: begin
        case (phase_q)
          PH_GAP: begin
            phase_d = PH_SETUP;
            if (can_abort) begin
              err_code_d = first_err(err_code_q, ERR_ABT);
              state_d    = S_STOP;
            end
          end
          PH_SETUP: phase_d = PH_ACCESS;
          default: begin
            if (pready) begin
              phase_d = PH_GAP;
              if (state_q == S_STOP) begin
                if (pslverr) err_code_d = first_err(err_code_q, ERR_SLV);
                state_d = S_FIN;
              end else if (pslverr) begin
                err_code_d = first_err(err_code_q, ERR_SLV);
                state_d    = S_STOP;
              end else if (can_abort) begin
                err_code_d = first_err(err_code_q, ERR_ABT);
                state_d    = S_STOP;
              end else begin
                case (state_q)
                  S_WR_TDR:  state_d = S_WR_LOAD;
                  S_WR_LOAD: state_d = S_WR_RUN;
                  S_WR_RUN: begin
                    state_d = S_POLL;
                    poll_d  = 16'd0;
                  end
                  S_POLL: begin
                    if (prdata[1:0] != 2'b00) begin
                      state_d = S_CLR;
                    end else begin
                      poll_d = poll_inc;
                      if (poll_inc >= POLL_LIMIT) begin
                        err_code_d = first_err(err_code_q, ERR_TMO);
                        state_d    = S_STOP;
                      end
                    end
                  end
                  S_CLR: begin
                    cnt_d   = cnt_dec;
                    poll_d  = 16'd0;
                    state_d = (cnt_dec == 4'd0) ? S_STOP : S_POLL;
                  end
                  default: state_d = state_q;
                endcase
              end
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_GAP;
      tdr_q      <= 8'h00;
      mode_q     <= 3'b000;
      cnt_q      <= 4'd0;
      poll_q     <= 16'd0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tdr_q      <= tdr_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: a randomized APB completer plus a transfer-level sequence model,
// with directed scenarios whose transfer logs are pinned against hand-written values.
`timescale 1ns/1ps
module tb_timer_seq_ctrl;
  localparam logic [15:0] PL = 16'd5;
  localparam int M_TDR = 0, M_LOAD = 1, M_RUN = 2, M_POLL = 3, M_CLR = 4, M_STOP = 5, M_END = 6;

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_tdr, cmd_tcr;
  logic [3:0] cmd_count;
  logic       abort;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic       done, err, busy;
  logic [1:0] err_code;

  always #5 pclk = ~pclk;

  timer_seq_ctrl #(
    .ADDR_TDR(8'h00), .ADDR_TCR(8'h01), .ADDR_TSR(8'h02), .POLL_LIMIT(PL)
  ) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tdr(cmd_tdr), .cmd_tcr(cmd_tcr), .cmd_count(cmd_count), .abort(abort),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .done(done), .err(err), .err_code(err_code), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] c_tdr, c_tcr;
  logic [3:0] c_count;
  int ev_mode, ev_nth, wait_max, w_idx, w_len, slv_idx, abort_idx;

  int m_stage, m_rem, m_polls, m_code;
  int rd_cnt;

  logic [7:0] log_a [256];
  logic       log_w [256];
  logic [7:0] log_d [256];
  int         log_acc [256];
  int         log_n;
  logic       fin_done_v, fin_err_v;
  logic [1:0] fin_code_v;

  logic [7:0] pin_a [8] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01};
  logic       pin_w [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] pin_d [8] = '{8'hF0, 8'hA1, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_defaults();
    c_tdr = 8'($urandom); c_tcr = 8'($urandom); c_count = 4'd1;
    ev_mode = 2; ev_nth = 1; wait_max = 0; w_idx = -1; w_len = 0;
    slv_idx = -1; abort_idx = -1;
  endtask

  // Next transfer the sequence must perform, derived from the command and sequence stage.
  task automatic exp_xfer(output logic [7:0] a, output logic w, output logic [7:0] d);
    a = 8'hFF; w = 1'b0; d = 8'h00;
    case (m_stage)
      M_TDR:  begin a = 8'h00; w = 1'b1; d = c_tdr; end
      M_LOAD: begin a = 8'h01; w = 1'b1; d = 8'h80 | (c_tcr & 8'h23); end
      M_RUN:  begin a = 8'h01; w = 1'b1; d = 8'h10 | (c_tcr & 8'h23); end
      M_POLL: begin a = 8'h02; w = 1'b0; end
      M_CLR:  begin a = 8'h02; w = 1'b1; end
      M_STOP: begin a = 8'h01; w = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic model_update(input logic slv, input logic [7:0] rd, input logic ab);
    if (m_stage == M_STOP) begin
      if (slv && m_code == 0) m_code = 1;
      m_stage = M_END;
    end else if (slv) begin
      if (m_code == 0) m_code = 1;
      m_stage = M_STOP;
    end else if (ab) begin
      if (m_code == 0) m_code = 3;
      m_stage = M_STOP;
    end else begin
      case (m_stage)
        M_TDR:  m_stage = M_LOAD;
        M_LOAD: m_stage = M_RUN;
        M_RUN:  begin m_stage = M_POLL; m_polls = 0; end
        M_POLL: begin
          if (rd[1:0] != 2'b00) m_stage = M_CLR;
          else begin
            m_polls++;
            if (m_polls >= int'(PL)) begin
              if (m_code == 0) m_code = 2;
              m_stage = M_STOP;
            end
          end
        end
        M_CLR: begin
          m_rem--;
          m_polls = 0;
          m_stage = (m_rem == 0) ? M_STOP : M_POLL;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tsr_value(output logic [7:0] v);
    logic ev;
    case (ev_mode)
      0: ev = ($urandom_range(0, 2) == 0);
      1: ev = 1'b0;
      2: ev = 1'b1;
      default: begin
        rd_cnt++;
        ev = (rd_cnt >= ev_nth);
        if (ev) rd_cnt = 0;
      end
    endcase
    if (ev_mode == 3) v = ev ? 8'h01 : 8'h00;
    else if (ev)      v = {6'($urandom), 2'($urandom_range(1, 3))};
    else              v = {6'($urandom), 2'b00};
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset = 1'b1; cmd_valid = 1'b0; pready = 1'b0; pslverr = 1'b0; abort = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic run_cmd();
    logic [7:0] s_a, s_d, ea, ed, rd;
    logic s_w, ew, slv, ab, prev_psel, fin_due, after_fin, finished;
    int acc, waits, xfer_idx;
    prev_psel = 1'b0; fin_due = 1'b0; after_fin = 1'b0; finished = 1'b0;
    acc = 0; waits = 0; xfer_idx = 0; s_a = 8'h00; s_d = 8'h00; s_w = 1'b0;
    @(negedge pclk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_tdr = c_tdr; cmd_tcr = c_tcr; cmd_count = c_count;
    m_stage = M_TDR; m_rem = (c_count == 4'd0) ? 1 : int'(c_count);
    m_polls = 0; m_code = 0; log_n = 0; rd_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      if (after_fin) begin
        chk("idle_after_fin", {busy, cmd_ready, done, err}, 4'b0100);
        chk("code_held", err_code, m_code[1:0]);
        finished = 1'b1;
        break;
      end else if (fin_due) begin
        chk("fin_done", done, m_code == 0);
        chk("fin_err", err, m_code != 0);
        chk("fin_code", err_code, m_code[1:0]);
        chk("fin_busy", {busy, psel}, 2'b10);
        fin_done_v = done; fin_err_v = err; fin_code_v = err_code;
        fin_due = 1'b0; after_fin = 1'b1;
        pready = 1'b0; pslverr = 1'b0; abort = 1'b0;
      end else begin
        chk("no_pulse", {done, err}, 2'b00);
        chk("busy_mid", {busy, cmd_ready}, 2'b10);
        if (psel && !penable) begin
          chk("setup_after_gap", prev_psel, 0);
          s_a = paddr; s_w = pwrite; s_d = pwdata; acc = 0;
          waits = (xfer_idx == w_idx) ? w_len : $urandom_range(0, wait_max);
          if (xfer_idx == abort_idx && waits == 0) waits = 1;
          pready = 1'b0; pslverr = 1'b0; abort = 1'b0;
        end else if (psel && penable) begin
          chk("access_stable", {prev_psel, paddr, pwrite, pwdata}, {1'b1, s_a, s_w, s_d});
          acc++;
          if (acc > waits) begin
            exp_xfer(ea, ew, ed);
            chk("xfer_addr", paddr, ea);
            chk("xfer_dir", pwrite, ew);
            if (ew) chk("xfer_wdata", pwdata, ed);
            slv = (xfer_idx == slv_idx);
            ab  = (xfer_idx == abort_idx);
            if (pwrite) rd = 8'($urandom);
            else tsr_value(rd);
            pready = 1'b1; pslverr = slv; prdata = rd; abort = ab;
            if (log_n < 256) begin
              log_a[log_n] = paddr; log_w[log_n] = pwrite;
              log_d[log_n] = pwdata; log_acc[log_n] = acc;
              log_n++;
            end
            model_update(slv, rd, ab);
            if (m_stage == M_END) fin_due = 1'b1;
            xfer_idx++;
          end else begin
            pready = 1'b0; pslverr = 1'b0; abort = (xfer_idx == abort_idx);
          end
        end else begin
          chk("penable_without_psel", penable, 0);
          pready = 1'b0; pslverr = 1'b0; abort = 1'b0; prdata = 8'($urandom);
        end
      end
      prev_psel = psel;
    end
    if (!finished) begin
      chk("seq_done_in_budget", finished, 1);
      do_reset();
    end
  endtask

  initial begin
    int cnt;
    logic found;
    preset = 1'b1; cmd_valid = 1'b0; cmd_tdr = 8'h00; cmd_tcr = 8'h00; cmd_count = 4'd0;
    abort = 1'b0; prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge pclk);
    chk("reset_state", {psel, penable, pwrite, paddr, pwdata, done, err, busy, err_code, cmd_ready},
        25'h1);
    preset = 1'b0;

    // Basic sequence, event on the third status read
    set_defaults(); c_tdr = 8'hF0; c_tcr = 8'h21; ev_mode = 3; ev_nth = 3;
    run_cmd();
    chk("pin32_len", log_n, 8);
    for (int i = 0; i < 8; i++) begin
      chk("pin32_addr", log_a[i], pin_a[i]);
      chk("pin32_dir", log_w[i], pin_w[i]);
      if (pin_w[i]) chk("pin32_data", log_d[i], pin_d[i]);
    end
    chk("pin32_done", {fin_done_v, fin_err_v}, 2'b10);
    chk("pin32_code", fin_code_v, 0);

    set_defaults(); c_count = 4'd3; ev_mode = 2;
    run_cmd();
    cnt = 0;
    for (int i = 0; i < log_n; i++) if (log_a[i] == 8'h02 && log_w[i]) cnt++;
    chk("pin33_clr_writes", cnt, 3);
    chk("pin33_len", log_n, 10);
    chk("pin33_done", fin_done_v, 1);

    set_defaults(); c_tdr = 8'hF0; c_tcr = 8'h21; ev_mode = 3; ev_nth = 3; w_idx = 1; w_len = 4;
    run_cmd();
    chk("pin34_access_cycles", log_acc[1], 5);
    chk("pin34_load_data", log_d[1], 8'hA1);
    chk("pin34_len", log_n, 8);
    chk("pin34_done", fin_done_v, 1);

    set_defaults(); c_tdr = 8'h12; c_tcr = 8'h03; slv_idx = 2;
    run_cmd();
    chk("pin35_len", log_n, 4);
    chk("pin35_stop", {log_a[3], log_w[3], log_d[3]}, {8'h01, 1'b1, 8'h00});
    chk("pin35_err", {fin_done_v, fin_err_v, fin_code_v}, 4'b0101);

    set_defaults(); ev_mode = 1;
    run_cmd();
    cnt = 0;
    for (int i = 0; i < log_n; i++) if (log_a[i] == 8'h02 && !log_w[i]) cnt++;
    chk("pin36_reads", cnt, 5);
    chk("pin36_len", log_n, 9);
    chk("pin36_err", {fin_err_v, fin_code_v}, 3'b110);

    set_defaults(); ev_mode = 1; abort_idx = 3;
    run_cmd();
    chk("pin37_len", log_n, 5);
    chk("pin37_waited", log_acc[3] >= 2, 1);
    chk("pin37_stop", {log_a[4], log_d[4]}, {8'h01, 8'h00});
    chk("pin37_err", {fin_err_v, fin_code_v}, 3'b111);

    for (int t = 0; t < 40; t++) begin
      set_defaults();
      c_count  = 4'($urandom_range(0, 5));
      ev_mode  = $urandom_range(0, 2);
      wait_max = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) slv_idx = $urandom_range(0, 10);
      if ($urandom_range(0, 4) == 0) abort_idx = $urandom_range(0, 10);
      run_cmd();
    end

    // Reset in the middle of a stalled transfer
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_tdr = 8'h5A; cmd_tcr = 8'h01; cmd_count = 4'd2;
    pready = 1'b0; found = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      if (psel && penable) begin
        preset = 1'b1;
        #1;
        chk("mid_reset_bus", {psel, penable, pwrite, paddr, pwdata}, 19'h0);
        chk("mid_reset_ctrl", {busy, cmd_ready, done, err, err_code}, 6'b010000);
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("mid_reset_reached_access", found, 1);
    @(negedge pclk);
    preset = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge pclk);
      chk("post_reset_quiet", {psel, done, err, cmd_ready}, 4'b0001);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
